// File: rtl/vga_scan_timing.sv
// Raster scan generator and registered VGA output stage.
// row/col drive the pixel pipeline; the returned RGB is registered with HS/VS/BLANK_N one pixel later.
module vga_scan_timing #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [12:0] row,
    output logic [12:0] col,
    output logic        active,
    input  logic [7:0]  i_VGA_R,
    input  logic [7:0]  i_VGA_G,
    input  logic [7:0]  i_VGA_B,
    output logic [7:0]  o_VGA_R,
    output logic [7:0]  o_VGA_G,
    output logic [7:0]  o_VGA_B,
    output logic        o_VGA_HS,
    output logic        o_VGA_VS,
    output logic        o_VGA_BLANK_N,
    output logic        frame_start,
    output logic        line_start
);

    localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
    localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
    localparam logic [12:0] H_TOTAL  = 13'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [12:0] V_TOTAL  = 13'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

    logic [12:0] r_row;
    logic [12:0] r_col;
    logic [7:0]  r_red;
    logic [7:0]  r_grn;
    logic [7:0]  r_blu;
    logic        r_hs;
    logic        r_vs;
    logic        r_blank_n;
    logic        r_frame_start;
    logic        r_line_start;

    logic        w_col_last;
    logic        w_row_last;
    logic        w_active;
    logic        w_hs_on;
    logic        w_vs_on;
    logic        w_origin;

    // >= rather than == keeps the counters bounded even from an unexpected value
    assign w_col_last = (r_col >= H_TOTAL - 13'd1);
    assign w_row_last = (r_row >= V_TOTAL - 13'd1);
    assign w_active   = (r_col < H_ACT) && (r_row < V_ACT);
    assign w_hs_on    = (r_col >= HS_START) && (r_col < HS_END);
    assign w_vs_on    = (r_row >= VS_START) && (r_row < VS_END);
    assign w_origin   = (r_row == 13'd0) && (r_col == 13'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row <= 13'd0;
            r_col <= 13'd0;
        end else if (pix_en) begin
            if (w_col_last) begin
                r_col <= 13'd0;
                r_row <= w_row_last ? 13'd0 : r_row + 13'd1;
            end else begin
                r_col <= r_col + 13'd1;
            end
        end
    end

    // Output stage samples the coordinates that are leaving stage 0 on this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_red         <= 8'd0;
            r_grn         <= 8'd0;
            r_blu         <= 8'd0;
            r_hs          <= ~SYNC_POL;
            r_vs          <= ~SYNC_POL;
            r_blank_n     <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else if (pix_en) begin
            r_red         <= w_active ? i_VGA_R : 8'd0;
            r_grn         <= w_active ? i_VGA_G : 8'd0;
            r_blu         <= w_active ? i_VGA_B : 8'd0;
            r_hs          <= w_hs_on ? SYNC_POL : ~SYNC_POL;
            r_vs          <= w_vs_on ? SYNC_POL : ~SYNC_POL;
            r_blank_n     <= w_active;
            r_frame_start <= w_origin;
            r_line_start  <= (r_col == 13'd0);
        end else begin
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end
    end

    assign row           = r_row;
    assign col           = r_col;
    assign active        = w_active;
    assign o_VGA_R       = r_red;
    assign o_VGA_G       = r_grn;
    assign o_VGA_B       = r_blu;
    assign o_VGA_HS      = r_hs;
    assign o_VGA_VS      = r_vs;
    assign o_VGA_BLANK_N = r_blank_n;
    assign frame_start   = r_frame_start;
    assign line_start    = r_line_start;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: a reduced-size raster under random pix_en/RGB/reset,
// plus a default-size instance run for two full lines.
module tb_vga_scan_timing;

    localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVA = 4, SVF = 1, SVS = 2, SVB = 1;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank_n;
        logic        fs;
        logic        ls;
        logic [23:0] rgb;
    } exp_t;

    localparam exp_t RESET_E = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0, fs: 1'b0, ls: 1'b0, rgb: 24'd0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_rst, s_pen;
    logic [7:0]  s_ri, s_gi, s_bi;
    logic [12:0] s_row, s_col;
    logic        s_act, s_hs, s_vs, s_bn, s_fs, s_ls;
    logic [7:0]  s_ro, s_go, s_bo;

    logic        f_rst, f_pen;
    logic [7:0]  f_ri, f_gi, f_bi;
    logic [12:0] f_row, f_col;
    logic        f_act, f_hs, f_vs, f_bn, f_fs, f_ls;
    logic [7:0]  f_ro, f_go, f_bo;

    vga_scan_timing #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(s_rst), .pix_en(s_pen), .row(s_row), .col(s_col), .active(s_act),
        .i_VGA_R(s_ri), .i_VGA_G(s_gi), .i_VGA_B(s_bi),
        .o_VGA_R(s_ro), .o_VGA_G(s_go), .o_VGA_B(s_bo),
        .o_VGA_HS(s_hs), .o_VGA_VS(s_vs), .o_VGA_BLANK_N(s_bn),
        .frame_start(s_fs), .line_start(s_ls)
    );

    vga_scan_timing dut_full (
        .clk(clk), .rst(f_rst), .pix_en(f_pen), .row(f_row), .col(f_col), .active(f_act),
        .i_VGA_R(f_ri), .i_VGA_G(f_gi), .i_VGA_B(f_bi),
        .o_VGA_R(f_ro), .o_VGA_G(f_go), .o_VGA_B(f_bo),
        .o_VGA_HS(f_hs), .o_VGA_VS(f_vs), .o_VGA_BLANK_N(f_bn),
        .frame_start(f_fs), .line_start(f_ls)
    );

    int n_vec = 0;
    int n_err = 0;

    longint s_n, f_n;
    exp_t   s_e, f_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Stage-1 contents after loading the n-th pixel of the scan (counted from reset)
    function automatic exp_t load_px(input longint n, input int ha, hfp, hsw, hbp,
                                     input int va, vfp, vsw, vbp, input logic [23:0] rgb_in);
        exp_t e;
        int ht, vt, c, r;
        logic act;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        c = int'(n % ht);
        r = int'((n / ht) % vt);
        act = (c < ha) && (r < va);
        e.hs      = (c >= ha + hfp && c < ha + hfp + hsw) ? 1'b0 : 1'b1;
        e.vs      = (r >= va + vfp && r < va + vfp + vsw) ? 1'b0 : 1'b1;
        e.blank_n = act;
        e.fs      = (r == 0) && (c == 0);
        e.ls      = (c == 0);
        e.rgb     = act ? rgb_in : 24'd0;
        return e;
    endfunction

    task automatic step_s(input logic r, input logic p);
        int ht, vt, ec, er;
        s_rst = r;
        s_pen = p;
        s_ri = 8'($urandom);
        s_gi = 8'($urandom);
        s_bi = 8'($urandom);
        @(posedge clk);
        if (r) begin
            s_n = 0;
            s_e = RESET_E;
        end else if (p) begin
            s_e = load_px(s_n, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, {s_ri, s_gi, s_bi});
            s_n++;
        end else begin
            s_e.fs = 1'b0;
            s_e.ls = 1'b0;
        end
        #1;
        ht = SHA + SHF + SHS + SHB;
        vt = SVA + SVF + SVS + SVB;
        ec = int'(s_n % ht);
        er = int'((s_n / ht) % vt);
        chk("s_row", 32'(s_row), 32'(er));
        chk("s_col", 32'(s_col), 32'(ec));
        chk("s_active", 32'(s_act), 32'((ec < SHA) && (er < SVA)));
        chk("s_hs", 32'(s_hs), 32'(s_e.hs));
        chk("s_vs", 32'(s_vs), 32'(s_e.vs));
        chk("s_blank_n", 32'(s_bn), 32'(s_e.blank_n));
        chk("s_rgb", 32'({s_ro, s_go, s_bo}), 32'(s_e.rgb));
        chk("s_frame_start", 32'(s_fs), 32'(s_e.fs));
        chk("s_line_start", 32'(s_ls), 32'(s_e.ls));
    endtask

    task automatic step_f(input logic r, input logic p);
        int ec, er;
        f_rst = r;
        f_pen = p;
        f_ri = 8'hAB;
        f_gi = 8'h12;
        f_bi = 8'hFF;
        @(posedge clk);
        if (r) begin
            f_n = 0;
            f_e = RESET_E;
        end else if (p) begin
            f_e = load_px(f_n, 640, 16, 96, 48, 480, 10, 2, 33, {f_ri, f_gi, f_bi});
            f_n++;
        end else begin
            f_e.fs = 1'b0;
            f_e.ls = 1'b0;
        end
        #1;
        ec = int'(f_n % 800);
        er = int'((f_n / 800) % 525);
        chk("f_row", 32'(f_row), 32'(er));
        chk("f_col", 32'(f_col), 32'(ec));
        chk("f_active", 32'(f_act), 32'((ec < 640) && (er < 480)));
        chk("f_hs", 32'(f_hs), 32'(f_e.hs));
        chk("f_vs", 32'(f_vs), 32'(f_e.vs));
        chk("f_blank_n", 32'(f_bn), 32'(f_e.blank_n));
        chk("f_rgb", 32'({f_ro, f_go, f_bo}), 32'(f_e.rgb));
        chk("f_frame_start", 32'(f_fs), 32'(f_e.fs));
        chk("f_line_start", 32'(f_ls), 32'(f_e.ls));
    endtask

    initial begin
        s_n = 0;
        f_n = 0;
        s_e = RESET_E;
        f_e = RESET_E;
        f_ri = 8'h0; f_gi = 8'h0; f_bi = 8'h0;
        f_rst = 1'b1;
        f_pen = 1'b0;

        // reset held three clocks with pix_en high
        repeat (3) step_s(1'b1, 1'b1);
        f_rst = 1'b0;

        // continuous pix_en: several frames of the reduced raster
        repeat (400) step_s(1'b0, 1'b1);

        // pix_en toggling 1,0,1,0
        for (int i = 0; i < 400; i++) step_s(1'b0, (i % 2) == 0);

        // random pix_en with occasional reset
        for (int i = 0; i < 1500; i++)
            step_s(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0));

        // mid-frame reset, then resume
        while (!(((s_n / 15) % 8) == 2 && (s_n % 15) == 5)) step_s(1'b0, 1'b1);
        step_s(1'b1, 1'b0);
        step_s(1'b0, 1'b0);
        repeat (200) step_s(1'b0, 1'b1);
        s_pen = 1'b0;

        // default-size raster: reset, then two full lines at full rate
        repeat (3) step_f(1'b1, 1'b1);
        repeat (1700) step_f(1'b0, 1'b1);
        step_f(1'b0, 1'b0);
        step_f(1'b1, 1'b0);
        step_f(1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_scan_timing.md
# vga_scan_timing

Raster scan generator and output stage for the VGA path. It produces the `row`/`col` pixel coordinates consumed by the RGB processing/overlay logic. It takes back that logic's combinational pixel result, registers it one pixel later, and aligns it with HSYNC, VSYNC and BLANK_N for the DAC. It is the coordinate-source / sync-sink end of the row/col/RGB interface.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of HS/VS (0 = active-low)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel advance strobe; counters and output stage update only on clk edges with pix_en=1
- row  out  13  current line counter, 0..V_TOTAL-1
- col  out  13  current pixel counter, 0..H_TOTAL-1
- active  out  1  1 when col<H_ACTIVE and row<V_ACTIVE
- i_VGA_R / i_VGA_G / i_VGA_B  in  8 each  processed pixel for current row/col (combinational from downstream)
- o_VGA_R / o_VGA_G / o_VGA_B  out  8 each  registered pixel to DAC
- o_VGA_HS  out  1  horizontal sync, registered
- o_VGA_VS  out  1  vertical sync, registered
- o_VGA_BLANK_N  out  1  1 during visible pixels, registered
- frame_start  out  1  one-clk pulse, first visible pixel of frame presented on outputs
- line_start  out  1  one-clk pulse, first pixel (col 0) of any line presented on outputs

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Stage 0 (counters, registered; row/col are the counter registers):
  - on pix_en, col increments.
  - col==H_TOTAL-1 → col=0 and row increments.
  - row==V_TOTAL-1 with col==H_TOTAL-1 → row=0.
  - Counters never exceed TOTAL-1.
- active is combinational from row/col.
- Stage 1 (output, registered on pix_en), computed from stage-0 values and i_VGA_*:
  - HS asserted (=SYNC_POL) iff H_ACTIVE+H_FP ≤ col < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - VS asserted iff V_ACTIVE+V_FP ≤ row < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - BLANK_N = active.
  - o_VGA_* = active ? i_VGA_* : 0. Blanking is forced to black regardless of input.
- frame_start = 1 on the clk where stage 1 loads from row=0,col=0. line_start likewise for col=0. Both pulses are cleared on the next clk whether or not pix_en is asserted.
- pix_en=0: every register holds, and pulses deassert.
- Widths: counters are 13 bits, with comparisons unsigned. Parameter sums must fit in 13 bits.

## Timing
- Reset (synchronous, dominant over pix_en) values:
  - row=0, col=0
  - o_VGA_R/G/B=0
  - o_VGA_HS = o_VGA_VS = ~SYNC_POL (deasserted)
  - o_VGA_BLANK_N=0
  - frame_start=0, line_start=0
- First pix_en after reset release: stage 1 loads (0,0), so BLANK_N=1 and frame_start and line_start pulse.
- Latency: the pixel for coordinate (r,c) appears on o_VGA_* exactly one pix_en edge after row/col show (r,c). HS/VS/BLANK_N carry the same one-stage delay, so they stay mutually aligned.
- Reset mid-frame: on the next clk the counters are 0,0 and the outputs take their reset values. There is no partial-line recovery.
- With pix_en=1 continuously: line period is 800 clks, frame period is 420000 clks, and HS low time is 96 clks.

## Test plan
- Reset check: assert rst for 3 clks with pix_en=1. Required: row=col=0, HS=VS=1, BLANK_N=0, RGB=0, no pulses. On the first pix_en after release, frame_start=1 for exactly 1 clk.
- Horizontal sync, pix_en=1: HS falls exactly one clk after col=656 and stays low 96 clks. BLANK_N is low for 160 clks per line. line_start period is 800 clks.
- Vertical sync and frame wrap: VS is low for exactly 1600 clks starting one clk after (row=490, col=0). frame_start pulses are spaced 420000 clks apart. Row wraps 524→0 at col 799→0.
- Pixel pass-through: drive i_VGA_R/G/B = 0xAB/0x12/0xFF. Required:
  - active pixels: the same values appear one clk later.
  - col≥640 or row≥480: outputs are 0x00/0x00/0x00.
- pix_en gating: toggle pix_en 1,0,1,0. Required:
  - counters and outputs advance only on pix_en=1 and hold otherwise.
  - line period is 1600 clks.
  - frame_start stays 1 clk wide.
- Mid-frame reset: assert rst at row=300, col=400 for 1 clk. Next clk: row=col=0, outputs at reset values. The first post-reset pix_en produces frame_start.
